// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and one-hot/index helpers for the N:1 arbitrated mux
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic logic onehot_bit(input int unsigned idx, input int unsigned k);
      return idx == k;
   endfunction

   function automatic int unsigned onehot_to_idx(input logic [15:0] oh);
      int unsigned idx;
      idx = 0;
      for (int k = 15; k >= 0; k--) begin
         if (oh[k]) idx = k;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting after the last granted channel
module rr_arbiter #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] last_grant,
   output logic            grant_valid,
   output logic [SELW-1:0] grant_idx
);

   always_comb begin
      int cand;
      cand        = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      // Offsets 1..N visit every channel once, ending on last_grant itself.
      for (int i = 1; i <= N; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= N) cand = cand - N;
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = SELW'(cand);
         end
      end
   end

endmodule

// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - N:1 registered mux with fixed-select or round-robin arbitration
module mux_nto1_rr #(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   import mux_pkg::*;

   localparam logic [SELW:0] N_L = (SELW+1)'(N);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_sel;
   logic             r_out_valid;
   logic [SELW-1:0]  r_last_grant;

   logic             w_free;
   logic             w_fix_valid;
   logic             w_rr_valid;
   logic [SELW-1:0]  w_rr_idx;
   logic             w_grant_valid;
   logic [SELW-1:0]  w_grant_idx;
   logic [WIDTH-1:0] w_grant_data;

   rr_arbiter #(.N(N), .SELW(SELW)) u_rr_arbiter (
      .req         (in_valid),
      .last_grant  (r_last_grant),
      .grant_valid (w_rr_valid),
      .grant_idx   (w_rr_idx)
   );

   assign w_free        = !r_out_valid || out_ready;
   assign w_fix_valid   = ({1'b0, sel} < N_L) && in_valid[sel];
   assign w_grant_idx   = (mode == MODE_RR) ? w_rr_idx : sel;
   // Reset gates the grant so no transfer is accepted while rst is high.
   assign w_grant_valid = !rst && w_free && ((mode == MODE_RR) ? w_rr_valid : w_fix_valid);

   always_comb begin
      in_ready     = '0;
      w_grant_data = '0;
      for (int k = 0; k < N; k++) begin
         if (w_grant_valid && onehot_bit(int'(w_grant_idx), k)) in_ready[k] = 1'b1;
         if (w_grant_idx == SELW'(k)) w_grant_data = in_data[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sel    <= '0;
         r_last_grant <= SELW'(N-1);
      end else if (w_grant_valid) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= w_grant_data;
         r_out_sel    <= w_grant_idx;
         r_last_grant <= w_grant_idx;
      end else if (w_free) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb/tb_mux_nto1_rr.sv - table-driven scoreboard bench for mux_nto1_rr (N=4, WIDTH=4)
module tb_mux_nto1_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [15:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_valid;
   logic        out_ready;

   always #5 clk = ~clk;

   mux_nto1_rr #(.WIDTH(4), .N(4), .SELW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [3:0] data;
      logic [1:0] sel;
   } word_t;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic        ready;
      logic [15:0] data;
      logic [3:0]  exp_rdy;
   } vec_t;

   word_t sb[$];
   vec_t  vecs[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input string tag, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic r, input logic [15:0] d,
                       input logic [3:0] exp_rdy);
      word_t w;
      int    g;
      mode = m; sel = s; in_valid = v; out_ready = r; in_data = d;
      @(negedge clk);
      check({tag, " out_valid"}, int'(out_valid), int'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
         check({tag, " out_data"}, int'(out_data), int'(sb[0].data));
         check({tag, " out_sel"}, int'(out_sel), int'(sb[0].sel));
         if (r) void'(sb.pop_front());
      end
      check({tag, " in_ready"}, int'(in_ready), int'(exp_rdy));
      if (exp_rdy != 4'b0000) begin
         g = 0;
         for (int k = 0; k < 4; k++) if (exp_rdy[k]) g = k;
         w.data = d[g*4 +: 4];
         w.sel  = 2'(g);
         sb.push_back(w);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // channel data: ch0=3, ch1=5, ch2=9, ch3=F
      vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b1, 16'hAAA3, 4'b0001});
      vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0001});
      vecs.push_back('{1'b0, 2'd1, 4'hF, 1'b1, 16'hF953, 4'b0010});
      vecs.push_back('{1'b0, 2'd2, 4'hF, 1'b1, 16'hF953, 4'b0100});
      vecs.push_back('{1'b0, 2'd3, 4'hF, 1'b1, 16'hF953, 4'b1000});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0001});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0010});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0100});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b1000});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0001});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0010});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0100});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b0, 16'hF953, 4'b0000});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b0, 16'hF953, 4'b0000});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b0, 16'hF953, 4'b0000});
      vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b1000});
      vecs.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 16'hF953, 4'b0010});
      vecs.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 16'hF953, 4'b1000});
      vecs.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 16'hF953, 4'b0010});
      vecs.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 16'hF953, 4'b1000});
      vecs.push_back('{1'b0, 2'd2, 4'hB, 1'b1, 16'hF953, 4'b0000});
      vecs.push_back('{1'b0, 2'd2, 4'hB, 1'b1, 16'hF953, 4'b0000});

      rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1; in_data = 16'hF953;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset in_ready", int'(in_ready), 0);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      check("reset out_sel", int'(out_sel), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sel, vecs[i].valid,
              vecs[i].ready, vecs[i].data, vecs[i].exp_rdy);
      end

      check("hold out_data", int'(out_data), 4'hF);
      check("hold out_sel", int'(out_sel), 3);

      // reset mid-stream with a word held and last grant = 0
      step("rs0", 1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0001);
      rst = 1'b1;
      @(negedge clk);
      check("rst in_ready", int'(in_ready), 0);
      check("rst out_valid before", int'(out_valid), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      check("rst out_valid after", int'(out_valid), 0);
      check("rst out_data after", int'(out_data), 0);
      check("rst out_sel after", int'(out_sel), 0);
      step("rs1", 1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0001);
      step("rs2", 1'b1, 2'd0, 4'hF, 1'b1, 16'hF953, 4'b0010);
      step("rs3", 1'b1, 2'd0, 4'h0, 1'b1, 16'hF953, 4'b0000);
      step("rs4", 1'b1, 2'd0, 4'h0, 1'b1, 16'hF953, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nto1_rr.md
MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 Parameter WIDTH, default 4: data width per channel in bits.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N): width of select and grant index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SELW  channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; one-hot or zero.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_sel  output  SELW  index of the channel whose word sits in out_data.
REQ-013 out_valid  output  1  out_data holds a word.
REQ-014 out_ready  input  1  downstream accepts the word.

Function
REQ-015 Output register "free" SHALL be defined as !out_valid || out_ready.
REQ-016 A grant to channel g SHALL be issued combinationally only when free=1 and in_valid[g]=1; in_ready = one-hot(g) if granted, else 0.
REQ-017 mode=0: g = sel; no grant if sel >= N or in_valid[sel]=0.
REQ-018 mode=1: g = first channel with in_valid=1, searching last_grant+1, last_grant+2, ... modulo N (wrap N-1 -> 0).
REQ-019 Transfer (in_valid[g] && in_ready[g]) SHALL load out_data <= channel g data, out_sel <= g, out_valid <= 1 on the next edge: latency 1 cycle.
REQ-020 When free=1 and no grant, out_valid SHALL go to 0 on the next edge; out_data/out_sel SHALL hold.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold and in_ready SHALL be 0.
REQ-022 Simultaneous drain and fill (out_valid=1, out_ready=1, grant present) SHALL replace the word in the same edge, sustaining 1 word/cycle.
REQ-023 last_grant SHALL update to g only on a transfer, in both modes; mode changes take effect on the same cycle without flushing the output.
REQ-024 A channel with in_valid held continuously SHALL be granted at least once every N transfers in mode=1 (no starvation).
REQ-025 in_data of non-granted channels SHALL have no effect on any output.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0, last_grant=N-1.
REQ-027 in_ready SHALL be all-zero while rst=1, regardless of in_valid.
REQ-028 Reset asserted mid-stream SHALL discard the held word; first grant after release in mode=1 searches from channel 0.

Structure
REQ-029 Shared package mux_pkg SHALL hold mode constants MODE_FIXED=0, MODE_RR=1 and the one-hot/index helper functions.
REQ-030 Round-robin search SHALL live in sub-module rr_arbiter (inputs req[N], last_grant; outputs grant_valid, grant_idx), purely combinational; registers stay in mux_nto1_rr.

Verification (N=4, WIDTH=4)
REQ-031 Fixed mode: mode=0, sel stepping 0..3, data A,B,C,D = 3,5,9,F, all valid, out_ready=1 -> out_data 3,5,9,F each one cycle after sel change, out_sel matches.
REQ-032 Round-robin: mode=1, all four valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 and out_valid=1 every cycle after the first.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles with word 9 from channel 2 -> out_data stays 9, in_ready=0000 throughout, next transfer after release is channel 3.
REQ-034 Sparse requests: mode=1, only channels 1 and 3 valid -> grants alternate 1,3,1,3; channel 0 and 2 never see in_ready.
REQ-035 Reset mid-stream: rst high for 1 cycle while out_valid=1 -> out_valid=0, out_data=0 next cycle; first subsequent mode=1 grant with all valid is channel 0.
REQ-036 Invalid select: mode=0, sel=2, in_valid=1011 -> in_ready=0000, out_valid drops to 0 after current word drains.
